// File: rtl/sha256_pkg.sv
// Shared types, round constants and initial hash values for the SHA-256 round engine.
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Element 0 (H0 / working variable a) occupies the most significant 32 bits.
  typedef word_t [0:7] hash_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  // Rotate right within a 32-bit word.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Word-wise modulo 2^32 addition of two hash values.
  function automatic hash_t hashAdd(input hash_t x, input hash_t y);
    hash_t s;
    for (int i = 0; i < 8; i++) s[i] = x[i] + y[i];
    return s;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: maps working variables a..h plus K and W to the next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t i_state,
  input  word_t i_k,
  input  word_t i_w,
  output hash_t o_state
);

  word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  word_t w_sigma1, w_ch, w_t1, w_sigma0, w_maj, w_t2;

  // Unpack the working variables and evaluate T1/T2, then shift a..h down one slot.
  always_comb begin
    w_a = i_state[0];
    w_b = i_state[1];
    w_c = i_state[2];
    w_d = i_state[3];
    w_e = i_state[4];
    w_f = i_state[5];
    w_g = i_state[6];
    w_h = i_state[7];
    w_sigma1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
    w_ch     = (w_e & w_f) ^ (~w_e & w_g);
    w_t1     = w_h + w_sigma1 + w_ch + i_k + i_w;
    w_sigma0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
    w_maj    = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    w_t2     = w_sigma0 + w_maj;
    o_state  = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
  end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine applying ROUNDS_PER_CYCLE rounds per accepted schedule beat.
// Keeps the chaining value across blocks and publishes a registered digest with a one-cycle pulse.
// Optional SHA-224 support is enabled by defining SHA256_ENGINE_SHA224_EN (adds port mode_224).
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          first_block,
`ifdef SHA256_ENGINE_SHA224_EN
  input  logic                          mode_224,
`endif
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [32*ROUNDS_PER_CYCLE-1:0] w_data,
  output logic                          busy,
  output logic                          digest_valid,
  output logic [255:0]                  digest
);

  localparam int BEATS = 64 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_badRpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t      r_state, w_nextState;
  hash_t       r_chain, r_work, r_digest;
  logic [6:0]  r_round;
  logic        r_digestValid;
  logic        w_accept, w_lastBeat;
  hash_t       w_iv, w_finalSum, w_digestNext;
  hash_t       w_stage [0:ROUNDS_PER_CYCLE];
`ifdef SHA256_ENGINE_SHA224_EN
  logic        r_mode224;
`endif

  assign w_accept   = w_valid && w_ready;
  // The last beat starts at round 64-RPC, so the counter tops out at exactly 64.
  assign w_lastBeat = (r_round == 7'((BEATS - 1) * ROUNDS_PER_CYCLE));

  // Chain ROUNDS_PER_CYCLE single-round stages; word i of w_data feeds round r+i.
  assign w_stage[0] = r_work;
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    sha256_round u_round (
      .i_state (w_stage[i]),
      .i_k     (K[r_round[5:0] + 6'(i)]),
      .i_w     (w_data[32*i +: 32]),
      .o_state (w_stage[i+1])
    );
  end

  // Select the initial hash value and form the digest from the final round output.
  always_comb begin
    w_finalSum = hashAdd(r_chain, w_stage[ROUNDS_PER_CYCLE]);
`ifdef SHA256_ENGINE_SHA224_EN
    w_iv         = mode_224 ? IV224 : IV256;
    w_digestNext = r_mode224 ? hash_t'({w_finalSum[0:6], 32'h0}) : w_finalSum;
`else
    w_iv         = IV256;
    w_digestNext = w_finalSum;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decode: start leaves IDLE, the last accepted beat enters FINAL.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ROUND;
      ROUND:   if (w_accept && w_lastBeat) w_nextState = FINAL;
      FINAL:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    w_ready      = (r_state == ROUND);
    busy         = (r_state != IDLE);
    digest_valid = r_digestValid;
    digest       = r_digest;
  end

  // Datapath: load working vars on start, advance them per beat, fold into the chain in FINAL.
  // The digest is registered on the last beat so it appears together with the FINAL-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain       <= IV256;
      r_work        <= '0;
      r_round       <= '0;
      r_digest      <= '0;
      r_digestValid <= 1'b0;
`ifdef SHA256_ENGINE_SHA224_EN
      r_mode224     <= 1'b0;
`endif
    end else begin
      r_digestValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_round <= '0;
            if (first_block) begin
              r_chain <= w_iv;
              r_work  <= w_iv;
`ifdef SHA256_ENGINE_SHA224_EN
              r_mode224 <= mode_224;
`endif
            end else begin
              r_work <= r_chain;
            end
          end
        end
        ROUND: begin
          if (w_accept) begin
            r_work  <= w_stage[ROUNDS_PER_CYCLE];
            r_round <= r_round + 7'(ROUNDS_PER_CYCLE);
            if (w_lastBeat) begin
              r_digest      <= w_digestNext;
              r_digestValid <= 1'b1;
            end
          end
        end
        FINAL: r_chain <= hashAdd(r_chain, r_work);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: known-answer vectors plus randomized blocks
// compared against a behavioural FIPS 180-4 model. Exercises RPC=1 and RPC=4 instances.
module tb_sha256_round_engine;
  import sha256_pkg::*;

  typedef logic [63:0][31:0] schedule_t;

  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
  localparam hash_t ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam hash_t TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0, start4 = 1'b0, firstBlock = 1'b0;
  logic         valid1 = 1'b0, valid4 = 1'b0;
  logic [31:0]  data1 = '0;
  logic [127:0] data4 = '0;
  logic         ready1, busy1, dv1, ready4, busy4, dv4;
  logic [255:0] digest1, digest4;
`ifdef SHA256_ENGINE_SHA224_EN
  logic         mode224 = 1'b0;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int cycleNo = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  sha256_round_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .first_block(firstBlock),
`ifdef SHA256_ENGINE_SHA224_EN
    .mode_224(mode224),
`endif
    .w_valid(valid1), .w_ready(ready1), .w_data(data1),
    .busy(busy1), .digest_valid(dv1), .digest(digest1)
  );

  sha256_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .first_block(firstBlock),
`ifdef SHA256_ENGINE_SHA224_EN
    .mode_224(mode224),
`endif
    .w_valid(valid4), .w_ready(ready4), .w_data(data4),
    .busy(busy4), .digest_valid(dv4), .digest(digest4)
  );

  // ---------------- behavioural reference model ----------------
  function automatic word_t refRotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic schedule_t refSchedule(input logic [511:0] blk);
    schedule_t w;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (refRotr(w[t-15], 7) ^ refRotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (refRotr(w[t-2], 17) ^ refRotr(w[t-2], 19) ^ (w[t-2] >> 10));
    return w;
  endfunction

  function automatic hash_t refCompress(input hash_t hIn, input schedule_t w);
    word_t v [8];
    word_t t1, t2;
    hash_t hOut;
    for (int i = 0; i < 8; i++) v[i] = hIn[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (refRotr(v[4], 6) ^ refRotr(v[4], 11) ^ refRotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (refRotr(v[0], 2) ^ refRotr(v[0], 13) ^ refRotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hOut[i] = hIn[i] + v[i];
    return hOut;
  endfunction

  function automatic logic [511:0] randomBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // ---------------- per-instance access ----------------
  function automatic logic getReady(input int rpc); return (rpc == 1) ? ready1 : ready4; endfunction
  function automatic logic getBusy(input int rpc);  return (rpc == 1) ? busy1  : busy4;  endfunction
  function automatic logic getDv(input int rpc);    return (rpc == 1) ? dv1    : dv4;    endfunction
  function automatic hash_t getDigest(input int rpc); return (rpc == 1) ? digest1 : digest4; endfunction

  task automatic setStart(input int rpc, input logic s);
    if (rpc == 1) start1 = s; else start4 = s;
  endtask

  task automatic driveBeat(input int rpc, input logic v, input schedule_t w, input int beat);
    if (rpc == 1) begin
      valid1 = v;
      data1  = v ? w[beat] : $urandom();
    end else begin
      valid4 = v;
      data4  = v ? {w[4*beat+3], w[4*beat+2], w[4*beat+1], w[4*beat]}
                 : {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic driveIdle(input int rpc);
    if (rpc == 1) valid1 = 1'b0; else valid4 = 1'b0;
  endtask

  // Runs one block starting at the current negedge (engine idle); returns what was observed.
  task automatic runBlock(input int rpc, input logic firstBlk, input schedule_t w, input bit gaps,
                          input int strayAt, output hash_t dig, output int latency,
                          output int protoErrs, output bit timedOut, output bit pulseOk,
                          output int pulseAt);
    int beats;
    int beat;
    int cyc;
    bit stray;
    logic v;
    beats = 64 / rpc; beat = 0; cyc = 0; stray = 0; protoErrs = 0;
    setStart(rpc, 1'b1);
    firstBlock = firstBlk;
    @(negedge clk); cyc = 1;
    setStart(rpc, 1'b0);
    firstBlock = 1'($urandom_range(0, 1));
    while (beat < beats && cyc < 600) begin
      if (getReady(rpc) !== 1'b1 || getBusy(rpc) !== 1'b1 || getDv(rpc) !== 1'b0) protoErrs++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      driveBeat(rpc, v, w, beat);
      if (beat == strayAt && !stray) begin
        stray = 1;
        setStart(rpc, 1'b1);
        firstBlock = 1'b1;
      end
      @(negedge clk); cyc++;
      setStart(rpc, 1'b0);
      if (v) beat++;
    end
    timedOut = (beat < beats);
    driveIdle(rpc);
    latency = cyc;
    pulseAt = cycleNo;
    dig = getDigest(rpc);
    pulseOk = (getDv(rpc) === 1'b1) && (getReady(rpc) === 1'b0) && (getBusy(rpc) === 1'b1);
    @(negedge clk);
    if (getDv(rpc) !== 1'b0 || getBusy(rpc) !== 1'b0 || getDigest(rpc) !== dig) pulseOk = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int rpc;
      rpc = (k == 0) ? 1 : 4;
      testsRun++;
      if (getDigest(rpc) !== hash_t'(0)) begin
        testsFailed++;
        $display("[TB] FAIL reset_digest rpc=%0d got %h expected 0", rpc, getDigest(rpc));
      end
      testsRun++;
      if ({getDv(rpc), getBusy(rpc), getReady(rpc)} !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL reset_flags rpc=%0d got dv/busy/ready=%b expected 000", rpc,
                 {getDv(rpc), getBusy(rpc), getReady(rpc)});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_abc(input int rpc, input bit gaps);
    hash_t dig; int lat, perr, pAt; bit tmo, pok;
    runBlock(rpc, 1'b1, refSchedule(ABC_BLK), gaps, -1, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== ABC_DIGEST || dig !== refCompress(IV256, refSchedule(ABC_BLK))) begin
      testsFailed++;
      $display("[TB] FAIL abc_digest rpc=%0d gaps=%0d got %h expected %h", rpc, gaps, dig, ABC_DIGEST);
    end
    testsRun++;
    if (perr != 0 || tmo || !pok) begin
      testsFailed++;
      $display("[TB] FAIL abc_protocol rpc=%0d gaps=%0d got errs=%0d timeout=%0d pulseOk=%0d expected 0/0/1",
               rpc, gaps, perr, tmo, pok);
    end
    if (!gaps) begin
      testsRun++;
      if (lat != 64 / rpc + 1) begin
        testsFailed++;
        $display("[TB] FAIL abc_latency rpc=%0d got %0d expected %0d", rpc, lat, 64 / rpc + 1);
      end
    end
  endtask

  task automatic test_two_block();
    hash_t dig; int lat, perr, pAt; bit tmo, pok;
    runBlock(1, 1'b1, refSchedule(TWO_BLK1), 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== refCompress(IV256, refSchedule(TWO_BLK1)) || !pok) begin
      testsFailed++;
      $display("[TB] FAIL two_block_first got %h pulseOk=%0d expected %h 1", dig, pok,
               refCompress(IV256, refSchedule(TWO_BLK1)));
    end
    runBlock(1, 1'b0, refSchedule(TWO_BLK2), 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== TWO_DIGEST || !pok || perr != 0) begin
      testsFailed++;
      $display("[TB] FAIL two_block_final got %h pulseOk=%0d errs=%0d expected %h", dig, pok, perr, TWO_DIGEST);
    end
  endtask

  task automatic test_stray_start();
    hash_t dig; int lat, perr, pAt; bit tmo, pok;
    runBlock(1, 1'b1, refSchedule(ABC_BLK), 1'b0, 20, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== ABC_DIGEST || lat != 65 || perr != 0) begin
      testsFailed++;
      $display("[TB] FAIL stray_start got %h lat=%0d errs=%0d expected %h lat=65 errs=0", dig, lat, perr, ABC_DIGEST);
    end
  endtask

  task automatic test_abort();
    hash_t dig; int lat, perr, pAt; bit tmo, pok;
    schedule_t w;
    w = refSchedule(ABC_BLK);
    start1 = 1'b1; firstBlock = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int b = 0; b < 30; b++) begin
      driveBeat(1, 1'b1, w, b);
      @(negedge clk);
    end
    rst = 1'b1;
    driveIdle(1);
    @(negedge clk);
    testsRun++;
    if ({dv1, busy1, ready1} !== 3'b000 || digest1 !== 256'h0) begin
      testsFailed++;
      $display("[TB] FAIL abort_reset got dv/busy/ready=%b digest=%h expected 000 and 0",
               {dv1, busy1, ready1}, digest1);
    end
    rst = 1'b0;
    // Chain must be back at IV256, so a non-first block of "abc" still gives the abc digest.
    runBlock(1, 1'b0, w, 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== ABC_DIGEST) begin
      testsFailed++;
      $display("[TB] FAIL abort_chain_iv got %h expected %h", dig, ABC_DIGEST);
    end
    runBlock(1, 1'b1, w, 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
    testsRun++;
    if (dig !== ABC_DIGEST || !pok) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart got %h pulseOk=%0d expected %h", dig, pok, ABC_DIGEST);
    end
  endtask

  task automatic test_back_to_back();
    hash_t dig, model; int lat, perr, pAt, prevAt; bit tmo, pok;
    logic [511:0] blk;
    model = IV256; prevAt = 0;
    for (int n = 0; n < 3; n++) begin
      blk = randomBlock();
      model = refCompress(model, refSchedule(blk));
      runBlock(4, (n == 0), refSchedule(blk), 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
      testsRun++;
      if (dig !== model || !pok) begin
        testsFailed++;
        $display("[TB] FAIL b2b_digest blk=%0d got %h expected %h", n, dig, model);
      end
      if (n > 0) begin
        testsRun++;
        if (pAt - prevAt != 18) begin
          testsFailed++;
          $display("[TB] FAIL b2b_spacing blk=%0d got %0d expected 18", n, pAt - prevAt);
        end
      end
      prevAt = pAt;
    end
  endtask

  task automatic test_random();
    hash_t dig, model; int lat, perr, pAt; bit tmo, pok;
    logic [511:0] blk;
    for (int k = 0; k < 4; k++) begin
      int rpc;
      rpc = (k % 2 == 0) ? 1 : 4;
      model = IV256;
      for (int n = 0; n < 2; n++) begin
        blk = randomBlock();
        model = refCompress(model, refSchedule(blk));
        runBlock(rpc, (n == 0), refSchedule(blk), 1'b1, -1, dig, lat, perr, tmo, pok, pAt);
        testsRun++;
        if (dig !== model || perr != 0 || tmo || !pok) begin
          testsFailed++;
          $display("[TB] FAIL random_msg rpc=%0d blk=%0d got %h errs=%0d timeout=%0d pulseOk=%0d expected %h",
                   rpc, n, dig, perr, tmo, pok, model);
        end
      end
    end
  endtask

`ifdef SHA256_ENGINE_SHA224_EN
  task automatic test_sha224();
    hash_t dig; int lat, perr, pAt; bit tmo, pok;
    hash_t expected;
    expected = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    mode224 = 1'b1;
    runBlock(4, 1'b1, refSchedule(ABC_BLK), 1'b0, -1, dig, lat, perr, tmo, pok, pAt);
    mode224 = 1'b0;
    testsRun++;
    if (dig !== expected) begin
      testsFailed++;
      $display("[TB] FAIL sha224_abc got %h expected %h", dig, expected);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_abc(1, 1'b0);
    test_abc(4, 1'b0);
    test_two_block();
    test_abc(1, 1'b1);
    test_abc(4, 1'b1);
    test_stray_start();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef SHA256_ENGINE_SHA224_EN
    test_sha224();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Parametrised SHA-256 compression engine. Consumes the expanded schedule words W[0..63] from the upstream message scheduler.
- Applies ROUNDS_PER_CYCLE rounds per accepted beat, keeps the chaining value internally across multi-block messages, and presents a registered digest with a one-cycle valid pulse.
- Sits between the message scheduler and the top-level hash controller. It replaces the fixed one-round-per-count core: it adds an internal round counter, a valid/ready word handshake, a start/busy/done protocol and a configurable unroll.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds applied per accepted beat. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- BEATS, 64/ROUNDS_PER_CYCLE, derived localparam (not overridable): beats per block.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin compression of one block. Sampled only in IDLE.
- first_block  in  1  sampled with start. 1 = load the IV as the chaining value first.
- w_valid  in  1  schedule beat valid.
- w_ready  out  1  engine accepts a beat. High only in ROUND.
- w_data  in  32*ROUNDS_PER_CYCLE  schedule words. [31:0] is the lowest-numbered round of the beat.
- busy  out  1  high in any state other than IDLE.
- digest_valid  out  1  one-cycle pulse; digest is updated in the same cycle.
- digest  out  256  H0 in [255:224] through H7 in [31:0]. Registered and held until the next update.

Behaviour:
- Reset is synchronous and active-high. Reset value of every output and register:
  - state = IDLE; chain = IV256; working vars a..h = 0; round counter = 0.
  - digest = 0; digest_valid = 0; busy = 0; w_ready = 0.
- State machine: IDLE -> ROUND -> FINAL -> IDLE.
- IDLE:
  - start = 1 with first_block = 1: chain <= IV and a..h <= IV.
  - start = 1 with first_block = 0: a..h <= chain.
  - On start: round counter <= 0, next state is ROUND.
- ROUND:
  - w_ready = 1. A beat is accepted when w_valid & w_ready.
  - On accept: a..h <= result of ROUNDS_PER_CYCLE chained rounds using K[r..r+RPC-1] and w_data; r <= r + RPC.
  - Without accept: all registers hold. Stalls are unbounded.
  - Accepting the beat with r == 64-RPC moves to FINAL.
- FINAL (one cycle, w_ready = 0):
  - chain <= chain + {a..h}, word-wise mod 2^32.
  - digest <= the same sum; digest_valid = 1 for this cycle only; next state IDLE.
- Latency: start is accepted in cycle 0. With w_valid held high, digest_valid asserts in cycle BEATS+1.
- Back-to-back: start may be asserted in the cycle immediately after FINAL. Each block then takes BEATS+2 cycles.
- start while busy is ignored and has no effect on state. first_block is ignored unless start is accepted.
- Arithmetic: all additions are 32-bit modulo 2^32 with no carry out. Round function is per FIPS 180-4:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
  - T2 = Σ0(a) + Maj(a,b,c)
- Reset mid-operation: rst has priority over every other input. It aborts immediately to the reset values; a partial block is discarded and chain returns to IV256.
- The round counter is 7 bits and never exceeds 64. No wrap-around occurs because the ROUND exit is decoded on r == 64-RPC.

Optional Feature:
- Macro: SHA256_ENGINE_SHA224_EN.
- When defined:
  - Adds input port mode_224 (1 bit), sampled with start when first_block = 1.
  - mode_224 = 1 selects the IV224 constants; the mode is latched for the message.
  - In SHA-224 mode, digest[31:0] is forced to 0 so that only H0..H6 are significant.
- When not defined: the port is absent, IV256 is always used, and the digest carries all 8 words.

Decomposition:
- Package sha256_pkg:
  - word_t (32-bit) and hash_t (8 x word_t) typedefs.
  - K[0:63] table, IV256, IV224.
  - State enum {IDLE, ROUND, FINAL}.
- Sub-module sha256_round: combinational single round mapping (a..h, K, W) to next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain via a generate loop.

Test Plan:
- Padded "abc", single block, first_block = 1, w_valid held high, run at RPC = 1 and RPC = 4 -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid pulses at cycle 65 and cycle 17 respectively.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnomnopnopq", second block sent with first_block = 0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with random w_valid gaps (about 50% duty) -> same digest as the first test. Registers hold during gaps, w_ready stays high in ROUND, and the pulse is exactly one cycle.
- start pulsed while busy at round 20, plus rst asserted at round 30 then an "abc" run restarted with first_block = 1 -> the stray start has no effect; after rst all outputs are 0; the restarted run produces the correct "abc" digest.
- With SHA256_ENGINE_SHA224_EN defined, mode_224 = 1, "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
